serial_spi_tx: RTL and testbench
================================

SERIAL_SPI_TX -- requirements
Module: serial_spi_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 25, clk_50 cycles per SCLK half-period (1 MHz SCLK at 50 MHz); legal range 2..65535.
REQ-002 SHALL provide port clk_50  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL provide port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port LOAD  input  1  level from upstream serial receiver; each rising edge marks a new valid byte.
REQ-005 SHALL provide port BYTEIN  input  8  byte from upstream receiver, stable while LOAD high.
REQ-006 SHALL provide port MISO  input  1  SPI slave data in.
REQ-007 SHALL provide port SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 SHALL provide port MOSI  output  1  SPI data out, MSB first.
REQ-009 SHALL provide port SS_N  output  1  active-low slave select.
REQ-010 SHALL provide port RXBYTE  output  8  byte captured from MISO during the last transfer.
REQ-011 SHALL provide port RX_VALID  output  1  one-cycle pulse when RXBYTE updates.
REQ-012 SHALL provide port BUSY  output  1  high whenever state is not IDLE or holding register is full.
REQ-013 SHALL provide port OVERRUN  output  1  sticky flag: byte dropped; cleared only by RESET.

Function
REQ-014 SHALL register LOAD into LOAD_d each cycle; accept pulse = LOAD & ~LOAD_d; LOAD held high yields exactly one accept.
REQ-015 SHALL, on accept, write BYTEIN into a one-byte holding register and set its full flag on that same clock edge.
REQ-016 SHALL, on accept with holding full and not emptied that cycle, drop BYTEIN, keep holding contents, set OVERRUN.
REQ-017 SHALL treat accept coinciding with holding-to-shift transfer as legal: new byte enters holding, no OVERRUN.
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-019 SHALL, in IDLE with holding full, copy holding to 8-bit shift register, clear full, drive SS_N low, MOSI = bit 7, enter SETUP on the next edge.
REQ-020 SHALL use a half-period counter cleared on every state entry; tick when counter = CLK_DIV-1, then counter returns to 0.
REQ-021 SHALL leave SETUP after one tick (SCLK low), entering SHIFT.
REQ-022 SHALL in SHIFT toggle SCLK on each tick; 16 ticks total, giving 8 rising and 8 falling edges.
REQ-023 SHALL sample MISO into receive shift register, MSB first, on each SCLK rising tick.
REQ-024 SHALL shift MOSI to next bit on falling ticks 1..7; MOSI unchanged on 8th falling tick.
REQ-025 SHALL enter HOLD after 16th tick (SCLK low, SS_N low), remain one tick, then drive SS_N high and enter GAP.
REQ-026 SHALL, on HOLD exit, load RXBYTE with receive shift register and pulse RX_VALID for exactly one clk_50 cycle.
REQ-027 SHALL remain in GAP one tick (SS_N high, SCLK low) then enter IDLE; queued byte starts on the following cycle.
REQ-028 SHALL hold SCLK low and SS_N high in IDLE and GAP; MOSI = 0 in IDLE.
REQ-029 SHALL keep SS_N low continuously from SETUP entry to HOLD exit: 18 half-periods per byte.

Reset
REQ-030 SHALL, while RESET high at an edge, force: state IDLE, SCLK 0, MOSI 0, SS_N 1, RXBYTE 0x00, RX_VALID 0, BUSY 0, OVERRUN 0, holding empty, LOAD_d 0, counters 0.
REQ-031 SHALL abort any transfer on RESET mid-operation with no RX_VALID pulse; outputs reach reset values one edge after RESET sampled high.
REQ-032 SHALL, with LOAD already high when RESET deasserts, accept that level as one new byte (LOAD_d reset to 0).

Verification
REQ-033 SHALL cover: RESET 3 cycles -> SS_N=1, SCLK=0, MOSI=0, BUSY=0, OVERRUN=0, RXBYTE=0x00.
REQ-034 SHALL cover: CLK_DIV=2, BYTEIN=0xA5 with LOAD rise, slave returns 0x3C -> MOSI 1,0,1,0,0,1,0,1 at 8 SCLK rises; SS_N low 36 cycles; RXBYTE=0x3C with one-cycle RX_VALID.
REQ-035 SHALL cover: LOAD held high 200 cycles with BYTEIN=0x81 -> exactly one transfer, OVERRUN=0.
REQ-036 SHALL cover: 0x11 then 0x22 during 0x11 SHIFT -> two transfers separated by GAP tick; then 0x33 while 0x44 is queued and 0x33's predecessor shifting -> OVERRUN=1, 0x33 not sent.
REQ-037 SHALL cover: RESET asserted on 4th SCLK rise of 0xF0 -> next edge SS_N=1, SCLK=0, no RX_VALID, holding empty, later byte 0x0F transfers normally.
REQ-038 SHALL cover: accept on the exact IDLE cycle holding moves to shift -> both bytes transferred in order, OVERRUN=0.

Source files
------------

// File: rtl/serial_spi_tx.sv
// serial_spi_tx: one-byte-buffered SPI master transmitter (mode 0, MSB first).
// Bytes arrive from an upstream serial receiver via a LOAD level whose rising
// edge marks a new byte.  The byte waits in a holding register while the
// previous one is still shifting.  Each transfer exchanges one byte on
// MOSI/MISO and posts the received byte on RXBYTE with a one-cycle RX_VALID.
//
// Ports
//   clk_50    in   system clock, rising edge
//   RESET     in   synchronous active-high reset
//   LOAD      in   upstream byte strobe (level; rising edge = new byte)
//   BYTEIN    in   [7:0] upstream byte, stable while LOAD high
//   MISO      in   slave data in
//   SCLK      out  SPI clock, idles low
//   MOSI      out  SPI data out, MSB first
//   SS_N      out  active-low slave select
//   RXBYTE    out  [7:0] byte received during the last completed transfer
//   RX_VALID  out  one-cycle pulse when RXBYTE updates
//   BUSY      out  transfer in progress or a byte is waiting
//   OVERRUN   out  sticky: a byte was dropped because the buffer was full
//
// state | meaning
// IDLE  | SS_N high, SCLK low; start a transfer when holding register full
// SETUP | SS_N low, MSB on MOSI, one half-period before the first SCLK rise
// SHIFT | 16 half-period ticks toggling SCLK (8 rises sample, 8 falls shift)
// HOLD  | SCLK low, SS_N still low for one half-period after the last fall
// GAP   | SS_N high for one half-period before the next transfer may start

module serial_spi_tx #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk_50,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [7:0] BYTEIN,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       SS_N,
    output logic [7:0] RXBYTE,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       OVERRUN
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [15:0] TICK_CNT = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  tick_q, tick_d;
    logic        load_q;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        sclk_q, sclk_d;
    logic        ss_n_q, ss_n_d;
    logic [7:0]  rxbyte_q, rxbyte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;

    logic accept;
    logic tick;
    logic start;

    assign accept = LOAD & ~load_q;
    assign tick   = (cnt_q == TICK_CNT);
    assign start  = (state_q == ST_IDLE) && hold_full_q;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        sclk_d      = sclk_q;
        ss_n_d      = ss_n_q;
        rxbyte_d    = rxbyte_q;
        rx_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    // MOSI is tx_sh_q[7], so loading the shifter presents the MSB
                    tx_sh_d = hold_q;
                    ss_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    tick_d  = 4'd0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    tick_d = tick_q + 4'd1;
                    // even tick index = SCLK rising, odd = falling
                    if (!tick_q[0]) begin
                        rx_sh_d = {rx_sh_q[6:0], MISO};
                    end else if (tick_q != 4'd15) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                    if (tick_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    ss_n_d     = 1'b1;
                    tx_sh_d    = 8'h00;
                    rxbyte_d   = rx_sh_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Holding register: the start cycle empties it, so a byte accepted
        // on that same edge takes the freed slot instead of overrunning.
        hold_d      = hold_q;
        hold_full_d = hold_full_q & ~start;
        overrun_d   = overrun_q;
        if (accept) begin
            if (!hold_full_d) begin
                hold_d      = BYTEIN;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Half-period counter restarts on every state change and every tick
        if ((state_d != state_q) || tick || (state_q == ST_IDLE)) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            tick_q      <= 4'd0;
            load_q      <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 8'h00;
            sclk_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            rxbyte_q    <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            load_q      <= LOAD;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            sclk_q      <= sclk_d;
            ss_n_q      <= ss_n_d;
            rxbyte_q    <= rxbyte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign SCLK     = sclk_q;
    assign MOSI     = tx_sh_q[7];
    assign SS_N     = ss_n_q;
    assign RXBYTE   = rxbyte_q;
    assign RX_VALID = rx_valid_q;
    assign BUSY     = (state_q != ST_IDLE) | hold_full_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_serial_spi_tx.sv
// Bench for serial_spi_tx: a bus-level slave model observes MOSI and answers
// on MISO, directed vectors cover the single-byte and corner-case sequences,
// and a random LOAD stream is compared with a timeline model of the buffer.

module tb_serial_spi_tx;

    localparam int D = 2;

    logic       clk_50 = 1'b0;
    logic       RESET;
    logic       LOAD;
    logic [7:0] BYTEIN;
    logic       MISO = 1'b0;
    logic       SCLK;
    logic       MOSI;
    logic       SS_N;
    logic [7:0] RXBYTE;
    logic       RX_VALID;
    logic       BUSY;
    logic       OVERRUN;

    always #5 clk_50 = ~clk_50;

    serial_spi_tx #(.CLK_DIV(D)) dut (
        .clk_50   (clk_50),
        .RESET    (RESET),
        .LOAD     (LOAD),
        .BYTEIN   (BYTEIN),
        .MISO     (MISO),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .SS_N     (SS_N),
        .RXBYTE   (RXBYTE),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- slave / bus monitor (samples on falling clk_50) -------
    bit         mon_en      = 1'b0;
    bit         use_fixed   = 1'b0;
    logic [7:0] fixed_resp  = 8'h00;
    logic       ss_prev     = 1'b1;
    logic       sclk_prev   = 1'b0;
    logic       rxv_prev    = 1'b0;
    int         bitcnt      = 0;
    logic [7:0] mosi_sh     = 8'h00;
    logic [7:0] cur_resp    = 8'h00;
    int         low_w       = 0;
    int         high_w      = 0;
    int         last_high_w = 0;
    int         rxv_count   = 0;
    logic [7:0] obs_tx_q[$];
    logic [7:0] exp_rx_q[$];

    always @(negedge clk_50) begin
        if (mon_en) begin
            if (ss_prev && !SS_N) begin
                cur_resp    = use_fixed ? fixed_resp : 8'($urandom);
                bitcnt      = 0;
                mosi_sh     = 8'h00;
                low_w       = 0;
                last_high_w = high_w;
                MISO        = cur_resp[7];
            end
            if (!sclk_prev && SCLK) begin
                mosi_sh = {mosi_sh[6:0], MOSI};
                bitcnt++;
            end
            if (sclk_prev && !SCLK && bitcnt < 8) begin
                MISO = cur_resp[3'(7 - bitcnt)];
            end
            if (!ss_prev && SS_N) begin
                if (bitcnt == 8) begin
                    obs_tx_q.push_back(mosi_sh);
                    exp_rx_q.push_back(cur_resp);
                    check("ss_n_low_cycles", low_w, 18 * D);
                end else if (!RESET) begin
                    check("bits_per_transfer", bitcnt, 8);
                end
                high_w = 0;
                MISO   = 1'b0;
            end
            if (!SS_N) low_w++;
            else high_w++;

            if (SS_N) check("sclk_low_while_deselected", SCLK, 1'b0);
            if (!BUSY) check("mosi_zero_when_idle", MOSI, 1'b0);
            if (RX_VALID) begin
                rxv_count++;
                check("rx_valid_one_cycle", rxv_prev, 1'b0);
                check("rx_valid_at_ss_rise", {ss_prev, SS_N}, 2'b01);
                check("rx_queue_depth", exp_rx_q.size(), 1);
                if (exp_rx_q.size() > 0) check("rxbyte_vs_slave", RXBYTE, exp_rx_q.pop_front());
            end
            ss_prev   = SS_N;
            sclk_prev = SCLK;
            rxv_prev  = RX_VALID;
        end
    end

    // ---------------- helpers ------------------------------------------------
    int obs_base = 0;

    function automatic int n_obs();
        return obs_tx_q.size() - obs_base;
    endfunction

    function automatic logic [7:0] obs_at(input int i);
        if (obs_base + i < obs_tx_q.size()) return obs_tx_q[obs_base + i];
        return 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] b);
        BYTEIN = b;
        LOAD   = 1'b1;
        tick();
        LOAD   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((BUSY !== 1'b0) && (k < budget)) begin
            tick();
            k++;
        end
        check({name, "_idle_in_time"}, k < budget, 1'b1);
        repeat (2) tick();
    endtask

    task automatic wait_sclk_rises(input string name, input int n, input int budget);
        int k = 0;
        int seen = 0;
        logic prev;
        while ((seen < n) && (k < budget)) begin
            prev = SCLK;
            tick();
            if (prev === 1'b0 && SCLK === 1'b1) seen++;
            k++;
        end
        check({name, "_sclk_rise_in_time"}, seen, n);
    endtask

    task automatic wait_ss_rise(input string name, input int budget);
        int k = 0;
        bit done = 1'b0;
        logic prev;
        while (!done && (k < budget)) begin
            prev = SS_N;
            tick();
            if (prev === 1'b0 && SS_N === 1'b1) done = 1'b1;
            k++;
        end
        check({name, "_ss_rise_in_time"}, done, 1'b1);
    endtask

    // ---------------- reference model: buffer occupancy on a timeline ------
    int         m_t;
    int         m_free_at;
    bit         m_full;
    logic [7:0] m_hold;
    bit         m_ovr;
    logic       m_load_prev;
    logic [7:0] m_sent[$];

    task automatic model_reset();
        m_t = 0; m_free_at = 0; m_full = 0; m_hold = 8'h00; m_ovr = 0; m_load_prev = 1'b0;
        m_sent.delete();
    endtask

    // One call per clock edge.  A transfer launched at edge s keeps the
    // engine busy (SETUP + 16 SHIFT + HOLD + GAP half-periods) until s+1+19*D.
    task automatic model_step(input logic ld, input logic [7:0] b);
        if (m_t >= m_free_at && m_full) begin
            m_sent.push_back(m_hold);
            m_full    = 0;
            m_free_at = m_t + 1 + 19 * D;
        end
        if (ld && !m_load_prev) begin
            if (!m_full) begin
                m_hold = b;
                m_full = 1;
            end else begin
                m_ovr = 1;
            end
        end
        m_load_prev = ld;
        m_t++;
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic [7:0] din;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int hi_left;
        int lo_left;
        int nmin;

        vecs[0] = '{din: 8'hA5, miso: 8'h3C, exp_mosi: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{din: 8'h00, miso: 8'hFF, exp_mosi: 8'h00, exp_rx: 8'hFF};
        vecs[2] = '{din: 8'hFF, miso: 8'h00, exp_mosi: 8'hFF, exp_rx: 8'h00};
        vecs[3] = '{din: 8'h81, miso: 8'h7E, exp_mosi: 8'h81, exp_rx: 8'h7E};
        vecs[4] = '{din: 8'h5A, miso: 8'hC3, exp_mosi: 8'h5A, exp_rx: 8'hC3};

        // Reset values
        RESET = 1'b1; LOAD = 1'b0; BYTEIN = 8'h00;
        repeat (3) tick();
        check("rst_ss_n", SS_N, 1'b1);
        check("rst_sclk", SCLK, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_overrun", OVERRUN, 1'b0);
        check("rst_rxbyte", RXBYTE, 8'h00);
        check("rst_rx_valid", RX_VALID, 1'b0);
        RESET  = 1'b0;
        mon_en = 1'b1;

        // Table: single isolated transfers with known slave replies
        use_fixed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fixed_resp = vecs[i].miso;
            obs_base   = obs_tx_q.size();
            r0         = rxv_count;
            pulse_load(vecs[i].din);
            wait_idle("vec", 200);
            check("vec_tx_count", n_obs(), 1);
            check("vec_mosi_byte", obs_at(0), vecs[i].exp_mosi);
            check("vec_rxbyte", RXBYTE, vecs[i].exp_rx);
            check("vec_rx_valid_pulses", rxv_count - r0, 1);
            check("vec_overrun", OVERRUN, 1'b0);
        end
        use_fixed = 1'b0;

        // LOAD held high for 200 cycles: exactly one byte
        obs_base = obs_tx_q.size();
        BYTEIN = 8'h81;
        LOAD   = 1'b1;
        repeat (200) tick();
        LOAD   = 1'b0;
        wait_idle("held", 200);
        check("held_tx_count", n_obs(), 1);
        check("held_byte", obs_at(0), 8'h81);
        check("held_overrun", OVERRUN, 1'b0);

        // Queued byte during SHIFT, then a third byte overruns
        obs_base = obs_tx_q.size();
        pulse_load(8'h11);
        wait_sclk_rises("q", 1, 100);
        pulse_load(8'h22);
        wait_idle("q", 300);
        check("q_tx_count", n_obs(), 2);
        check("q_first", obs_at(0), 8'h11);
        check("q_second", obs_at(1), 8'h22);
        check("q_gap_cycles", last_high_w, D + 1);
        check("q_overrun", OVERRUN, 1'b0);

        obs_base = obs_tx_q.size();
        pulse_load(8'h55);
        wait_sclk_rises("ovr", 1, 100);
        pulse_load(8'h44);
        repeat (3) tick();
        pulse_load(8'h33);
        check("ovr_flag_set", OVERRUN, 1'b1);
        wait_idle("ovr", 300);
        check("ovr_tx_count", n_obs(), 2);
        check("ovr_first", obs_at(0), 8'h55);
        check("ovr_second", obs_at(1), 8'h44);
        check("ovr_sticky", OVERRUN, 1'b1);

        // Reset clears sticky overrun and RXBYTE
        RESET = 1'b1;
        repeat (3) tick();
        check("rst2_overrun", OVERRUN, 1'b0);
        check("rst2_rxbyte", RXBYTE, 8'h00);
        RESET = 1'b0;

        // Reset on the 4th SCLK rise aborts the transfer
        obs_base = obs_tx_q.size();
        pulse_load(8'hF0);
        wait_sclk_rises("abort", 4, 100);
        RESET = 1'b1;
        r0 = rxv_count;
        tick();
        check("abort_ss_n", SS_N, 1'b1);
        check("abort_sclk", SCLK, 1'b0);
        check("abort_mosi", MOSI, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        repeat (2) tick();
        RESET = 1'b0;
        repeat (10) tick();
        check("abort_no_rx_valid", rxv_count - r0, 0);
        check("abort_no_tx", n_obs(), 0);
        pulse_load(8'h0F);
        wait_idle("abort_next", 200);
        check("abort_next_count", n_obs(), 1);
        check("abort_next_byte", obs_at(0), 8'h0F);
        check("abort_next_rx_valid", rxv_count - r0, 1);

        // LOAD already high when reset releases: one accept
        RESET  = 1'b1;
        BYTEIN = 8'h6B;
        LOAD   = 1'b1;
        repeat (3) tick();
        obs_base = obs_tx_q.size();
        RESET = 1'b0;
        repeat (100) tick();
        LOAD = 1'b0;
        wait_idle("rlvl", 200);
        check("rlvl_tx_count", n_obs(), 1);
        check("rlvl_byte", obs_at(0), 8'h6B);
        check("rlvl_overrun", OVERRUN, 1'b0);

        // Accept on the very edge the queued byte moves to the shifter
        obs_base = obs_tx_q.size();
        pulse_load(8'hA1);
        wait_sclk_rises("edge", 1, 100);
        pulse_load(8'hB2);
        wait_ss_rise("edge", 200);
        repeat (D) tick();
        pulse_load(8'hC3);
        wait_idle("edge", 400);
        check("edge_overrun", OVERRUN, 1'b0);
        check("edge_tx_count", n_obs(), 3);
        check("edge_first", obs_at(0), 8'hA1);
        check("edge_second", obs_at(1), 8'hB2);
        check("edge_third", obs_at(2), 8'hC3);

        // Random LOAD stream against the timeline model
        LOAD = 1'b0;
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        model_reset();
        obs_base = obs_tx_q.size();
        hi_left = 0;
        lo_left = 5;
        for (int c = 0; c < 3000; c++) begin
            if (LOAD) begin
                if (hi_left == 0) begin
                    LOAD    = 1'b0;
                    lo_left = $urandom_range(0, 60);
                end else begin
                    hi_left--;
                end
            end else begin
                if (lo_left == 0) begin
                    LOAD    = 1'b1;
                    BYTEIN  = 8'($urandom);
                    hi_left = $urandom_range(0, 4);
                end else begin
                    lo_left--;
                end
            end
            model_step(LOAD, BYTEIN);
            tick();
        end
        LOAD = 1'b0;
        if (m_full) m_sent.push_back(m_hold);
        wait_idle("rand", 400);
        check("rand_tx_count", n_obs(), m_sent.size());
        nmin = (n_obs() < m_sent.size()) ? n_obs() : m_sent.size();
        for (int i = 0; i < nmin; i++) begin
            check("rand_tx_byte", obs_at(i), m_sent[i]);
        end
        check("rand_overrun", OVERRUN, m_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
